// File: rtl/pc_gen_if.sv
// Fetch-side handshake and redirect bundle for pc_gen.
// master = PC generator, slave = fetch/memory plus later stages.
interface pc_gen_if #(
   parameter int ADDR_W = 32
) ();
   logic              stall;
   logic              if_ready;
   logic              halt;
   logic              br_valid;
   logic [ADDR_W-1:0] br_target;
   logic              trap_valid;
   logic [ADDR_W-1:0] trap_target;
   logic [ADDR_W-1:0] pc;
   logic              ce;
   logic              flush;
   logic              misalign;

   modport master (
      input  stall, if_ready, halt,
      input  br_valid, br_target,
      input  trap_valid, trap_target,
      output pc, ce, flush, misalign
   );

   modport slave (
      output stall, if_ready, halt,
      output br_valid, br_target,
      output trap_valid, trap_target,
      input  pc, ce, flush, misalign
   );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch: sequential step,
// stall/back-pressure hold, branch/trap redirect, halt/resume.
module pc_gen #(
   parameter int                  ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]   RESET_VECTOR = '0,
   parameter int                  INST_BYTES   = 4
) (
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INST_BYTES - 1);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

   state_t            state;
   logic [ADDR_W-1:0] pc_q;
   logic              ce_q;
   logic              flush_q;
   logic              mis_q;

   logic [ADDR_W-1:0] pc_nxt;
   logic              fl_nxt;
   logic              mis_nxt;
   logic              br_bad;

   assign br_bad = |(bus.br_target & MASK);

   // Traps bypass the alignment check; a bad branch only raises misalign.
   always_comb begin
      pc_nxt  = pc_q;
      fl_nxt  = 1'b0;
      mis_nxt = 1'b0;
      if (bus.trap_valid) begin
         pc_nxt = bus.trap_target;
         fl_nxt = 1'b1;
      end else if (bus.br_valid && !br_bad) begin
         pc_nxt = bus.br_target;
         fl_nxt = 1'b1;
      end else if (bus.br_valid) begin
         mis_nxt = 1'b1;
      end else if (state == RUN && !bus.stall
                   && ce_q && bus.if_ready) begin
         pc_nxt = pc_q + STEP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pc_q    <= RESET_VECTOR;
         ce_q    <= 1'b0;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               state <= bus.halt ? HALT : RUN;
               ce_q  <= !bus.halt;
            end
            RUN, HALT: begin
               pc_q    <= pc_nxt;
               flush_q <= fl_nxt;
               mis_q   <= mis_nxt;
               state   <= bus.halt ? HALT : RUN;
               ce_q    <= !bus.halt;
            end
            default: begin
               state <= IDLE;
               ce_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc       = pc_q;
   assign bus.ce       = ce_q;
   assign bus.flush    = flush_q;
   assign bus.misalign = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized run against a
// behavioural model, on three parameter sets sharing one stimulus.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        if_ready = 1'b1;
   logic        halt = 1'b0;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = '0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_target = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_gen_if #(.ADDR_W(32)) b0 ();
   pc_gen_if #(.ADDR_W(8))  b1 ();
   pc_gen_if #(.ADDR_W(32)) b2 ();

   assign b0.stall = stall;       assign b1.stall = stall;       assign b2.stall = stall;
   assign b0.if_ready = if_ready; assign b1.if_ready = if_ready; assign b2.if_ready = if_ready;
   assign b0.halt = halt;         assign b1.halt = halt;         assign b2.halt = halt;
   assign b0.br_valid = br_valid; assign b1.br_valid = br_valid; assign b2.br_valid = br_valid;
   assign b0.trap_valid = trap_valid;
   assign b1.trap_valid = trap_valid;
   assign b2.trap_valid = trap_valid;
   assign b0.br_target = br_target;
   assign b1.br_target = br_target[7:0];
   assign b2.br_target = br_target;
   assign b0.trap_target = trap_target;
   assign b1.trap_target = trap_target[7:0];
   assign b2.trap_target = trap_target;

   pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'h100), .INST_BYTES(4))
      u0 (.clk(clk), .rst(rst), .bus(b0));
   pc_gen #(.ADDR_W(8), .RESET_VECTOR(8'hF0), .INST_BYTES(4))
      u1 (.clk(clk), .rst(rst), .bus(b1));
   pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'h100), .INST_BYTES(2))
      u2 (.clk(clk), .rst(rst), .bus(b2));

   logic [31:0] opc [3];
   logic        oce [3];
   logic        ofl [3];
   logic        omis[3];

   assign opc[0] = b0.pc; assign opc[1] = {24'h0, b1.pc}; assign opc[2] = b2.pc;
   assign oce[0] = b0.ce; assign oce[1] = b1.ce; assign oce[2] = b2.ce;
   assign ofl[0] = b0.flush; assign ofl[1] = b1.flush; assign ofl[2] = b2.flush;
   assign omis[0] = b0.misalign; assign omis[1] = b1.misalign; assign omis[2] = b2.misalign;

   // Model parameters and state, one slot per DUT.
   int          ib [3] = '{4, 4, 2};
   logic [31:0] msk[3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};
   logic [31:0] rv [3] = '{32'h100, 32'hF0, 32'h100};
   logic [31:0] m_pc [3];
   bit          m_ce [3];
   bit          m_fl [3];
   bit          m_mis[3];
   bit          m_run[3];
   bit          m_live[3];

   function automatic void mdl_reset(int k);
      m_pc[k] = rv[k]; m_ce[k] = 0; m_fl[k] = 0; m_mis[k] = 0;
      m_run[k] = 0; m_live[k] = 0;
   endfunction

   function automatic void mdl_edge(int k);
      m_fl[k] = 0;
      m_mis[k] = 0;
      if (m_live[k]) begin
         if (trap_valid) begin
            m_pc[k] = trap_target & msk[k]; m_fl[k] = 1;
         end else if (br_valid && (br_target % ib[k]) == 0) begin
            m_pc[k] = br_target & msk[k]; m_fl[k] = 1;
         end else if (br_valid) begin
            m_mis[k] = 1;
         end else if (m_run[k] && !stall && m_ce[k] && if_ready) begin
            m_pc[k] = (m_pc[k] + ib[k]) & msk[k];
         end
      end
      m_live[k] = 1;
      m_run[k] = !halt;
      m_ce[k] = !halt;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; if_ready = 1; halt = 0;
      br_valid = 0; trap_valid = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      step(); step();
      checks++; if (oce[0] !== 1'b0) begin errors++; $display("FAIL rst_ce got %b exp 0", oce[0]); end
      checks++; if (opc[0] !== 32'h100) begin errors++; $display("FAIL rst_pc got %h exp 00000100", opc[0]); end
      checks++; if (opc[1] !== 32'hF0) begin errors++; $display("FAIL rst_pc8 got %h exp 000000f0", opc[1]); end
      checks++; if (ofl[0] !== 1'b0 || omis[0] !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b exp 00", ofl[0], omis[0]); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp;
      rst = 0;
      step();
      checks++; if (oce[0] !== 1'b1) begin errors++; $display("FAIL seq_ce got %b exp 1", oce[0]); end
      exp = 32'h100;
      for (int i = 0; i < 3; i++) begin
         checks++; if (opc[0] !== exp) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, opc[0], exp); end
         exp += 4;
         step();
      end
      rst = 1;
      #1;
      checks++; if (opc[0] !== 32'h100 || oce[0] !== 1'b0) begin
         errors++; $display("FAIL async_rst got pc %h ce %b exp 00000100 0", opc[0], oce[0]);
      end
      rst = 0;
      step(); step(); step();
      checks++; if (opc[0] !== 32'h108) begin errors++; $display("FAIL rerun_pc got %h exp 00000108", opc[0]); end
   endtask

   task automatic test_backpressure();
      if_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (opc[0] !== 32'h108) begin errors++; $display("FAIL bp_hold%0d got %h exp 00000108", i, opc[0]); end
      end
      stall = 1; if_ready = 1;
      step();
      checks++; if (opc[0] !== 32'h108) begin errors++; $display("FAIL stall_hold got %h exp 00000108", opc[0]); end
      stall = 0;
      step();
      checks++; if (opc[0] !== 32'h10C) begin errors++; $display("FAIL bp_release got %h exp 0000010c", opc[0]); end
   endtask

   task automatic test_redirect();
      trap_valid = 1; trap_target = 32'h8;
      br_valid = 1; br_target = 32'h200;
      step();
      checks++; if (opc[0] !== 32'h8 || ofl[0] !== 1'b1) begin
         errors++; $display("FAIL trap_prio got pc %h fl %b exp 00000008 1", opc[0], ofl[0]);
      end
      trap_valid = 0; br_valid = 0;
      step();
      checks++; if (ofl[0] !== 1'b0 || opc[0] !== 32'hC) begin
         errors++; $display("FAIL trap_after got pc %h fl %b exp 0000000c 0", opc[0], ofl[0]);
      end
      br_valid = 1; br_target = 32'h200; stall = 1;
      step();
      checks++; if (opc[0] !== 32'h200 || ofl[0] !== 1'b1) begin
         errors++; $display("FAIL br_stall got pc %h fl %b exp 00000200 1", opc[0], ofl[0]);
      end
      br_target = 32'h300; stall = 0;
      step();
      checks++; if (opc[0] !== 32'h300 || ofl[0] !== 1'b1) begin
         errors++; $display("FAIL back_to_back got pc %h fl %b exp 00000300 1", opc[0], ofl[0]);
      end
   endtask

   task automatic test_misalign();
      br_valid = 1; br_target = 32'h202;
      step();
      checks++; if (opc[0] !== 32'h300 || omis[0] !== 1'b1 || ofl[0] !== 1'b0) begin
         errors++; $display("FAIL mis4 got pc %h mis %b fl %b exp 00000300 1 0", opc[0], omis[0], ofl[0]);
      end
      checks++; if (opc[2] !== 32'h202 || omis[2] !== 1'b0 || ofl[2] !== 1'b1) begin
         errors++; $display("FAIL mis2 got pc %h mis %b fl %b exp 00000202 0 1", opc[2], omis[2], ofl[2]);
      end
      br_valid = 0;
      step();
      checks++; if (omis[0] !== 1'b0 || opc[0] !== 32'h304) begin
         errors++; $display("FAIL mis_after got pc %h mis %b exp 00000304 0", opc[0], omis[0]);
      end
      trap_valid = 1; trap_target = 32'h1001;
      step();
      trap_valid = 0;
      checks++; if (opc[0] !== 32'h1001 || ofl[0] !== 1'b1) begin
         errors++; $display("FAIL trap_unaligned got pc %h fl %b exp 00001001 1", opc[0], ofl[0]);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp8 [5] = '{32'hF0, 32'hF4, 32'hF8, 32'hFC, 32'h00};
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (opc[1] !== exp8[i]) begin errors++; $display("FAIL wrap%0d got %h exp %h", i, opc[1], exp8[i]); end
      end
   endtask

   task automatic test_halt();
      checks++; if (opc[0] !== 32'h110) begin errors++; $display("FAIL halt_pre got %h exp 00000110", opc[0]); end
      halt = 1; if_ready = 0;
      step();
      checks++; if (oce[0] !== 1'b0 || opc[0] !== 32'h110) begin
         errors++; $display("FAIL halt_enter got pc %h ce %b exp 00000110 0", opc[0], oce[0]);
      end
      if_ready = 1;
      step();
      checks++; if (opc[0] !== 32'h110) begin errors++; $display("FAIL halt_hold got %h exp 00000110", opc[0]); end
      br_valid = 1; br_target = 32'h300;
      step();
      checks++; if (opc[0] !== 32'h300 || ofl[0] !== 1'b1 || oce[0] !== 1'b0) begin
         errors++; $display("FAIL halt_br got pc %h fl %b ce %b exp 00000300 1 0", opc[0], ofl[0], oce[0]);
      end
      br_valid = 0;
      step();
      checks++; if (ofl[0] !== 1'b0 || oce[0] !== 1'b0) begin
         errors++; $display("FAIL halt_fl got fl %b ce %b exp 0 0", ofl[0], oce[0]);
      end
      halt = 0;
      step();
      checks++; if (oce[0] !== 1'b1 || opc[0] !== 32'h300) begin
         errors++; $display("FAIL resume got pc %h ce %b exp 00000300 1", opc[0], oce[0]);
      end
      step();
      checks++; if (opc[0] !== 32'h304) begin errors++; $display("FAIL resume_seq got %h exp 00000304", opc[0]); end
   endtask

   task automatic test_random();
      idle_inputs();
      rst = 1;
      step();
      for (int k = 0; k < 3; k++) mdl_reset(k);
      rst = 0;
      for (int n = 0; n < 3000; n++) begin
         stall = ($urandom_range(0, 3) == 0);
         if_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) halt = !halt;
         br_valid = ($urandom_range(0, 5) == 0);
         br_target = $urandom & 32'hFFFF_FFF8;
         if ($urandom_range(0, 2) == 0) br_target[2:0] = 3'($urandom);
         trap_valid = ($urandom_range(0, 14) == 0);
         trap_target = $urandom;
         @(posedge clk);
         for (int k = 0; k < 3; k++) mdl_edge(k);
         #1;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (opc[k] !== m_pc[k] || oce[k] !== m_ce[k]
                || ofl[k] !== m_fl[k] || omis[k] !== m_mis[k]) begin
               errors++;
               $display("FAIL rnd%0d cyc %0d got pc %h ce %b fl %b mis %b exp pc %h ce %b fl %b mis %b",
                        k, n, opc[k], oce[k], ofl[k], omis[k],
                        m_pc[k], m_ce[k], m_fl[k], m_mis[k]);
            end
         end
         if ($urandom_range(0, 199) == 0) begin
            rst = 1;
            #1;
            for (int k = 0; k < 3; k++) begin
               mdl_reset(k);
               checks++;
               if (opc[k] !== m_pc[k] || oce[k] !== 1'b0) begin
                  errors++;
                  $display("FAIL rnd_rst%0d got pc %h ce %b exp %h 0", k, opc[k], oce[k], m_pc[k]);
               end
            end
            rst = 0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_misalign();
      test_wrap();
      test_halt();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. It produces the fetch address `pc` and fetch-enable `ce` toward instruction memory, using a valid/ready handshake. It advances sequentially by a configurable instruction size, holds on stall or back-pressure, and redirects on branch and trap requests from later stages. It also supports halt/resume and flags misaligned branch targets.

## Interface
- `ADDR_W`, 32: width of `pc` and all target buses.
- `RESET_VECTOR`, 0: `pc` value after reset; must be aligned to `INST_BYTES`.
- `INST_BYTES`, 4: sequential increment and alignment granule; power of two, 1..8.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `stall`  in  1: pipeline stall; holds `pc` and `ce` unchanged.
- `if_ready`  in  1: instruction memory accepts the current address this cycle.
- `halt`  in  1: level request to stop fetching.
- `br_valid`  in  1: branch/jump redirect request (EX stage).
- `br_target`  in  ADDR_W: branch target.
- `trap_valid`  in  1: trap/exception redirect request.
- `trap_target`  in  ADDR_W: trap vector.
- `pc`  out  ADDR_W: current fetch address (registered).
- `ce`  out  1: fetch request valid (registered).
- `flush`  out  1: one-cycle pulse, the cycle after a redirect is applied; kills in-flight fetch.
- `misalign`  out  1: one-cycle pulse, the cycle after a misaligned `br_target` is rejected.

## Operation
- States: IDLE, RUN, HALT.
- Reset (async, any time, including mid-redirect): state=IDLE, `pc`=RESET_VECTOR, `ce`=0, `flush`=0, `misalign`=0.
- IDLE: at the first edge with `rst` low, go to RUN (or to HALT if `halt`=1). `ce` follows the new state. `pc` stays RESET_VECTOR.
- Per-edge priority in RUN, highest first:
  1. `trap_valid`: `pc`←`trap_target`, `flush`←1.
  2. `br_valid` with aligned target: `pc`←`br_target`, `flush`←1.
  3. `br_valid` with misaligned target (`br_target[log2(INST_BYTES)-1:0]`≠0): target ignored, `pc` holds, `misalign`←1, no flush.
  4. `stall`: hold.
  5. `ce`&&`if_ready`: `pc`←`pc`+INST_BYTES.
  6. Otherwise: hold.
- Redirects apply regardless of `stall` or `if_ready`. An unaccepted request is abandoned. `trap_valid` is never blocked by alignment.
- Handshake rule: while `ce`=1 and `if_ready`=0, `pc` must stay stable unless a redirect is applied.
- Sequential increment is modulo 2^ADDR_W: all-ones-aligned address + INST_BYTES wraps to 0, with no flag.
- `halt`=1 at an edge in RUN: go to HALT, `ce`←0. A redirect at the same edge is still applied to `pc` and `flush`.
- HALT: `ce`=0, `pc` holds, `stall` and `if_ready` ignored. Redirects still update `pc` and pulse `flush`.
- HALT → RUN at the first edge with `halt`=0; `ce`←1 at that edge.
- `flush` and `misalign` are single-cycle pulses. Back-to-back events give back-to-back pulses.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Redirect latency: request sampled at edge N; `pc`=target and `flush`=1 visible after edge N. `flush` deasserts after edge N+1 unless there is another redirect.
- Fetch throughput: one address per cycle while `if_ready`=1 and `stall`=0.
- After reset release: `ce`=1 becomes visible after the first edge; the first accepted address is RESET_VECTOR.

## Test plan
- Reset/sequential (ADDR_W=32, INST_BYTES=4, RESET_VECTOR=0x100), `if_ready`=1: `ce`=0 during reset. After release, `pc` runs 0x100, 0x104, 0x108, one per cycle. Assert `rst` mid-run: `pc`=0x100 and `ce`=0 immediately, without waiting for a clock edge.
- Back-pressure/stall: `if_ready`=0 for 3 cycles at `pc`=0x108 → `pc` holds 0x108. Then `stall`=1 with `if_ready`=1 → still holds. Release both → next `pc`=0x10C.
- Redirect priority: `trap_valid`(0x8)+`br_valid`(0x200) at the same edge → `pc`=0x8, `flush`=1 for exactly one cycle. `br_valid`(0x200)+`stall`=1 → `pc`=0x200.
- Misalign: `br_valid` with `br_target`=0x202 → `pc` unchanged, `misalign`=1 for one cycle, `flush`=0. Same test with INST_BYTES=2 → branch taken.
- Wrap: ADDR_W=8, `pc` reaches 0xFC, `if_ready`=1 → `pc`=0x00.
- Halt: `halt`=1 at `pc`=0x110 → `ce`=0, `pc` holds. `br_valid`(0x300) during HALT → `pc`=0x300, `flush` pulse, `ce` stays 0. Drop `halt` → `ce`=1, fetch resumes at 0x300.
